// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
// Debugger-facing sequencer for a five-stage pipeline. It owns the load,
// run, single-step, drain and halted modes. Per cycle it produces the stage
// register enables and the bubble flushes from the current mode and the
// hazard inputs.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_cmd_valid/i_cmd   debugger command (0 NOP,1 LOAD,2 LOAD_END,3 RUN,4 STEP,5 PAUSE)
//   o_cmd_ready         command is consumed when valid & ready
//   i_load_use          load-use hazard in ID
//   i_branch_taken      branch resolved taken in MEM
//   i_halt_decoded      HALT opcode in ID
//   o_*_en              stage register enables (PC, IF/ID, ID/EX, EX/MEM, MEM/WB)
//   o_*_flush           load a bubble into IF/ID, ID/EX, EX/MEM
//   o_imem_grant        loader owns the instruction-memory write port
//   o_pipe_rst          one-cycle pipeline register clear after LOAD_END
//   o_state             current state encoding
//   o_halted            high in HALTED
//   o_step_done         one-cycle pulse in the cycle after a STEP
//   o_cycle_cnt         saturating count of advancing cycles
//
// state  | meaning
// IDLE   | pipeline frozen, waiting for LOAD/RUN/STEP
// LOAD   | loader owns instruction memory until LOAD_END
// RUN    | free-running, advancing every cycle
// STEP   | exactly one advancing cycle
// DRAIN  | HALT seen, emptying EX/MEM/WB with fetch frozen
// HALTED | drained, only LOAD leaves
module pipeline_sequencer #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    input  logic [2:0]       i_cmd,
    output logic             o_cmd_ready,
    input  logic             i_load_use,
    input  logic             i_branch_taken,
    input  logic             i_halt_decoded,
    output logic             o_pc_en,
    output logic             o_if_id_en,
    output logic             o_id_ex_en,
    output logic             o_ex_mem_en,
    output logic             o_mem_wb_en,
    output logic             o_if_id_flush,
    output logic             o_id_ex_flush,
    output logic             o_ex_mem_flush,
    output logic             o_imem_grant,
    output logic             o_pipe_rst,
    output logic [2:0]       o_state,
    output logic             o_halted,
    output logic             o_step_done,
    output logic [CNT_W-1:0] o_cycle_cnt
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_STEP   = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;
    localparam logic [2:0] ST_HALTED = 3'd5;

    localparam logic [2:0] CMD_LOAD     = 3'd1;
    localparam logic [2:0] CMD_LOAD_END = 3'd2;
    localparam logic [2:0] CMD_RUN      = 3'd3;
    localparam logic [2:0] CMD_STEP     = 3'd4;
    localparam logic [2:0] CMD_PAUSE    = 3'd5;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [3:0]       drain_cnt_q, drain_cnt_d;
    logic             step_done_q;
    logic             pipe_rst_q;
    logic [CNT_W-1:0] cycle_cnt_q;
    logic             cmd_ready;
    logic             cmd_acc;
    logic             load_end_acc;
    logic             advancing;

    assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD) ||
                       (state_q == ST_RUN)  || (state_q == ST_HALTED);
    assign cmd_acc   = i_cmd_valid && cmd_ready;
    assign advancing = (state_q == ST_RUN) || (state_q == ST_STEP) ||
                       (state_q == ST_DRAIN);

    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        load_end_acc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_acc) begin
                    case (i_cmd)
                        CMD_LOAD: state_d = ST_LOAD;
                        CMD_RUN:  state_d = ST_RUN;
                        CMD_STEP: state_d = ST_STEP;
                        default:  state_d = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD: begin
                if (cmd_acc && (i_cmd == CMD_LOAD_END)) begin
                    state_d      = ST_IDLE;
                    load_end_acc = 1'b1;
                end
            end
            ST_RUN: begin
                // HALT takes priority over a PAUSE arriving in the same cycle
                if (i_halt_decoded) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end else if (cmd_acc && (i_cmd == CMD_PAUSE)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (i_halt_decoded) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == 4'd0) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_cnt_d = drain_cnt_q - 4'd1;
                end
            end
            ST_HALTED: begin
                if (cmd_acc && (i_cmd == CMD_LOAD)) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                drain_cnt_d = 4'd0;
            end
        endcase
    end

    // DRAIN keeps fetch frozen even on a taken branch; the branch only
    // squashes the younger latches.
    always_comb begin
        o_pc_en        = 1'b0;
        o_if_id_en     = 1'b0;
        o_id_ex_en     = 1'b0;
        o_ex_mem_en    = 1'b0;
        o_mem_wb_en    = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_flush  = 1'b0;
        o_ex_mem_flush = 1'b0;
        if (advancing) begin
            o_pc_en     = 1'b1;
            o_if_id_en  = 1'b1;
            o_id_ex_en  = 1'b1;
            o_ex_mem_en = 1'b1;
            o_mem_wb_en = 1'b1;
            if (state_q == ST_DRAIN) begin
                o_pc_en       = 1'b0;
                o_if_id_en    = 1'b0;
                o_id_ex_flush = 1'b1;
                if (i_branch_taken) begin
                    o_if_id_flush  = 1'b1;
                    o_ex_mem_flush = 1'b1;
                end
            end else if (i_branch_taken) begin
                o_if_id_flush  = 1'b1;
                o_id_ex_flush  = 1'b1;
                o_ex_mem_flush = 1'b1;
            end else if (i_load_use) begin
                o_pc_en       = 1'b0;
                o_if_id_en    = 1'b0;
                o_id_ex_flush = 1'b1;
            end
        end
    end

    // o_pipe_rst is registered: it rises on the edge that accepts LOAD_END,
    // so it is high for the first IDLE cycle; the cycle counter clears on
    // that same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= 4'd0;
            step_done_q <= 1'b0;
            pipe_rst_q  <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            step_done_q <= (state_q == ST_STEP);
            pipe_rst_q  <= load_end_acc;
            if (load_end_acc) begin
                cycle_cnt_q <= '0;
            end else if (advancing && !(&cycle_cnt_q)) begin
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_cmd_ready  = cmd_ready;
    assign o_imem_grant = (state_q == ST_LOAD);
    assign o_pipe_rst   = pipe_rst_q;
    assign o_state      = state_q;
    assign o_halted     = (state_q == ST_HALTED);
    assign o_step_done  = step_done_q;
    assign o_cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer (DRAIN_CYCLES=4, CNT_W=32).
module tb_pipeline_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_cmd_valid = 1'b0;
    logic [2:0]  i_cmd = 3'd0;
    logic        o_cmd_ready;
    logic        i_load_use = 1'b0;
    logic        i_branch_taken = 1'b0;
    logic        i_halt_decoded = 1'b0;
    logic        o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en;
    logic        o_if_id_flush, o_id_ex_flush, o_ex_mem_flush;
    logic        o_imem_grant, o_pipe_rst, o_halted, o_step_done;
    logic [2:0]  o_state;
    logic [31:0] o_cycle_cnt;

    logic [4:0]  en_vec;
    logic [2:0]  fl_vec;
    int errors = 0;
    int checks = 0;

    assign en_vec = {o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en};
    assign fl_vec = {o_if_id_flush, o_id_ex_flush, o_ex_mem_flush};

    pipeline_sequencer #(.DRAIN_CYCLES(4), .CNT_W(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd), .o_cmd_ready(o_cmd_ready),
        .i_load_use(i_load_use), .i_branch_taken(i_branch_taken),
        .i_halt_decoded(i_halt_decoded),
        .o_pc_en(o_pc_en), .o_if_id_en(o_if_id_en), .o_id_ex_en(o_id_ex_en),
        .o_ex_mem_en(o_ex_mem_en), .o_mem_wb_en(o_mem_wb_en),
        .o_if_id_flush(o_if_id_flush), .o_id_ex_flush(o_id_ex_flush),
        .o_ex_mem_flush(o_ex_mem_flush), .o_imem_grant(o_imem_grant),
        .o_pipe_rst(o_pipe_rst), .o_state(o_state), .o_halted(o_halted),
        .o_step_done(o_step_done), .o_cycle_cnt(o_cycle_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic cmd(input logic [2:0] c);
        i_cmd_valid = 1'b1;
        i_cmd = c;
        tick();
        i_cmd_valid = 1'b0;
        i_cmd = 3'd0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", o_state); end
        checks++; if (o_cycle_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", o_cycle_cnt); end
        checks++; if ({en_vec, fl_vec} !== 8'h00) begin errors++; $display("FAIL reset_en_fl: got %b expected 00000000", {en_vec, fl_vec}); end
        checks++; if ({o_imem_grant, o_halted, o_step_done, o_pipe_rst} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {o_imem_grant, o_halted, o_step_done, o_pipe_rst}); end
        checks++; if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", o_cmd_ready); end
    endtask

    task automatic test_load();
        cmd(3'd1);
        checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL load_state: got %0d expected 1", o_state); end
        checks++; if (o_imem_grant !== 1'b1) begin errors++; $display("FAIL load_grant: got %b expected 1", o_imem_grant); end
        checks++; if (en_vec !== 5'b00000) begin errors++; $display("FAIL load_en: got %b expected 00000", en_vec); end
        cmd(3'd4);
        checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL load_ignore_step: got %0d expected 1", o_state); end
        cmd(3'd2);
        checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL load_end_state: got %0d expected 0", o_state); end
        checks++; if (o_imem_grant !== 1'b0) begin errors++; $display("FAIL load_end_grant: got %b expected 0", o_imem_grant); end
        checks++; if (o_pipe_rst !== 1'b1) begin errors++; $display("FAIL load_end_pipe_rst: got %b expected 1", o_pipe_rst); end
        checks++; if (o_cycle_cnt !== 32'd0) begin errors++; $display("FAIL load_end_cnt: got %0d expected 0", o_cycle_cnt); end
        tick();
        checks++; if (o_pipe_rst !== 1'b0) begin errors++; $display("FAIL pipe_rst_width: got %b expected 0", o_pipe_rst); end
    endtask

    task automatic test_run_pause();
        int bad = 0;
        cmd(3'd3);
        checks++; if (o_state !== 3'd2) begin errors++; $display("FAIL run_state: got %0d expected 2", o_state); end
        // ten RUN cycles; PAUSE is presented in the tenth
        for (int k = 0; k < 10; k++) begin
            if (k == 9) begin i_cmd_valid = 1'b1; i_cmd = 3'd5; end
            #1;
            if ({en_vec, fl_vec} !== 8'b11111_000) bad++;
            tick();
        end
        i_cmd_valid = 1'b0; i_cmd = 3'd0;
        checks++; if (bad != 0) begin errors++; $display("FAIL run_clean_en: got %0d bad cycles expected 0", bad); end
        checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL pause_state: got %0d expected 0", o_state); end
        checks++; if (o_cycle_cnt !== 32'd10) begin errors++; $display("FAIL run_cnt: got %0d expected 10", o_cycle_cnt); end
        checks++; if ({en_vec, fl_vec} !== 8'h00) begin errors++; $display("FAIL idle_en: got %b expected 00000000", {en_vec, fl_vec}); end
    endtask

    task automatic test_hazards();
        cmd(3'd3);
        i_load_use = 1'b1;
        #1;
        checks++; if ({en_vec, fl_vec} !== 8'b00111_010) begin errors++; $display("FAIL load_use: got %b expected 00111010", {en_vec, fl_vec}); end
        i_branch_taken = 1'b1;
        #1;
        checks++; if ({en_vec, fl_vec} !== 8'b11111_111) begin errors++; $display("FAIL branch_over_load_use: got %b expected 11111111", {en_vec, fl_vec}); end
        i_load_use = 1'b0;
        #1;
        checks++; if ({en_vec, fl_vec} !== 8'b11111_111) begin errors++; $display("FAIL branch_only: got %b expected 11111111", {en_vec, fl_vec}); end
        i_branch_taken = 1'b0;
        i_halt_decoded = 1'b0;
        cmd(3'd5);
        checks++; if (o_cycle_cnt !== 32'd11) begin errors++; $display("FAIL hazard_cnt: got %0d expected 11", o_cycle_cnt); end
    endtask

    task automatic test_step();
        int pulses = 0;
        cmd(3'd1);
        cmd(3'd2);
        tick();
        for (int k = 0; k < 3; k++) begin
            cmd(3'd4);
            checks++; if (o_state !== 3'd3) begin errors++; $display("FAIL step_state: got %0d expected 3", o_state); end
            checks++; if (o_cmd_ready !== 1'b0) begin errors++; $display("FAIL step_ready: got %b expected 0", o_cmd_ready); end
            checks++; if (o_step_done !== 1'b0) begin errors++; $display("FAIL step_done_early: got %b expected 0", o_step_done); end
            tick();
            if (o_step_done === 1'b1) pulses++;
            checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL step_return: got %0d expected 0", o_state); end
            tick();
            if (o_step_done === 1'b1) pulses++;
        end
        checks++; if (pulses != 3) begin errors++; $display("FAIL step_pulses: got %0d expected 3", pulses); end
        checks++; if (o_cycle_cnt !== 32'd3) begin errors++; $display("FAIL step_cnt: got %0d expected 3", o_cycle_cnt); end
    endtask

    task automatic test_halt_drain();
        int bad = 0;
        cmd(3'd3);
        // PAUSE in the same cycle as HALT: DRAIN must win
        i_halt_decoded = 1'b1;
        i_cmd_valid = 1'b1; i_cmd = 3'd5;
        tick();
        i_cmd_valid = 1'b0; i_cmd = 3'd0;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin i_halt_decoded = 1'b0; i_load_use = 1'b1; end
            if (k == 2) begin i_load_use = 1'b0; i_branch_taken = 1'b1; end
            if (k == 3) i_branch_taken = 1'b0;
            #1;
            if (o_state !== 3'd4 || o_cmd_ready !== 1'b0) bad++;
            if (k == 2) begin
                if ({en_vec, fl_vec} !== 8'b00111_111) bad++;
            end else begin
                if ({en_vec, fl_vec} !== 8'b00111_010) bad++;
            end
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL drain_cycles: got %0d bad cycles expected 0", bad); end
        checks++; if (o_state !== 3'd5 || o_halted !== 1'b1) begin errors++; $display("FAIL halted: got state %0d halted %b expected 5 1", o_state, o_halted); end
        checks++; if (en_vec !== 5'b00000) begin errors++; $display("FAIL halted_en: got %b expected 00000", en_vec); end
        cmd(3'd3);
        checks++; if (o_state !== 3'd5) begin errors++; $display("FAIL halted_run_ignored: got %0d expected 5", o_state); end
        cmd(3'd1);
        checks++; if (o_state !== 3'd1 || o_halted !== 1'b0) begin errors++; $display("FAIL halted_load: got state %0d halted %b expected 1 0", o_state, o_halted); end
        cmd(3'd2);
    endtask

    task automatic test_drain_reset();
        cmd(3'd3);
        i_halt_decoded = 1'b1;
        tick();
        i_halt_decoded = 1'b0;
        tick();
        checks++; if (o_state !== 3'd4) begin errors++; $display("FAIL drain2_state: got %0d expected 4", o_state); end
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL drain_rst_state: got %0d expected 0", o_state); end
        checks++; if (o_cycle_cnt !== 32'd0) begin errors++; $display("FAIL drain_rst_cnt: got %0d expected 0", o_cycle_cnt); end
        checks++; if ({en_vec, fl_vec, o_imem_grant, o_halted, o_step_done, o_pipe_rst} !== 12'h000) begin errors++; $display("FAIL drain_rst_outs: got %b expected 000000000000", {en_vec, fl_vec, o_imem_grant, o_halted, o_step_done, o_pipe_rst}); end
        tick();
        checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL drain_rst_stays_idle: got %0d expected 0", o_state); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_run_pause();
        test_hazards();
        test_step();
        test_halt_drain();
        test_drain_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
